// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Holds the FSM state encoding, the id-width helper and the "no hold limit" sentinel.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam int MAX_HOLD_UNLIMITED = 0;

  // A single requester still needs a 1-bit index, so the width never drops to zero.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// Requester-side bundle of the hold arbiter: request/last lines in, grant status out.
interface rr_arbiter_hold_if
  import arb_pkg::*;
#(
  parameter int N = 8
);

  logic [N-1:0]              req;
  logic [N-1:0]              last;
  logic [N-1:0]              gnt;
  logic [id_width(N)-1:0]    gnt_id;
  logic                      busy;
  logic                      timeout;

  modport master (
    output req,
    output last,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  last,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping to 0.
// The request vector is doubled so the wrap becomes a plain lowest-set-bit search.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N   = 8,
  localparam int IdW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   pick_onehot_o,
  output logic [IdW-1:0] pick_id_o,
  output logic           pick_valid_o
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] masked_req;

  assign dbl_req    = {req_i, req_i};
  assign masked_req = dbl_req & ({(2*N){1'b1}} << ptr_i);

  // Upper copy catches the lines below ptr, giving them the lowest priority.
  always_comb begin
    logic found;
    found         = 1'b0;
    pick_id_o     = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (masked_req[i] && !found) begin
        found     = 1'b1;
        pick_id_o = (i >= N) ? IdW'(i - N) : IdW'(i);
      end
    end
    pick_valid_o  = found;
    pick_onehot_o = found ? (N'(1) << pick_id_o) : '0;
  end

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter that keeps a grant across a multi-cycle transaction.
// Release on last, abandon or hold limit re-arbitrates at the same edge, so handoff has no bubble.
module rr_arbiter_hold
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  rr_arbiter_hold_if.slave  bus
);

  localparam int IdW  = id_width(N);
  localparam int CntW = id_width((MAX_HOLD == MAX_HOLD_UNLIMITED) ? 2 : MAX_HOLD);
  localparam logic [CntW-1:0] CntLast =
    CntW'((MAX_HOLD == MAX_HOLD_UNLIMITED) ? 0 : MAX_HOLD - 1);

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic            busy_q;
  logic            timeout_q, timeout_d;

  logic [N-1:0]    pick_onehot;
  logic [IdW-1:0]  pick_id;
  logic            pick_valid;
  logic            cur_last;
  logic            cur_req;
  logic            rel_force;
  logic            release_now;

  rr_pick #(.N(N)) u_pick (
    .req_i         (bus.req),
    .ptr_i         (ptr_q),
    .pick_onehot_o (pick_onehot),
    .pick_id_o     (pick_id),
    .pick_valid_o  (pick_valid)
  );

  // gnt is one-hot, so masking avoids indexing with an id that may exceed N-1.
  assign cur_last    = |(bus.last & gnt_q);
  assign cur_req     = |(bus.req & gnt_q);
  assign rel_force   = (MAX_HOLD != MAX_HOLD_UNLIMITED) && (hold_cnt_q == CntLast);
  assign release_now = cur_last || !cur_req || rel_force;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_HOLD;
          gnt_d      = pick_onehot;
          gnt_id_d   = pick_id;
          hold_cnt_d = '0;
          ptr_d      = (pick_id == IdW'(N - 1)) ? '0 : pick_id + IdW'(1);
        end
      end
      ARB_HOLD: begin
        if (release_now) begin
          timeout_d = rel_force && !cur_last && cur_req;
          if (pick_valid) begin
            gnt_d      = pick_onehot;
            gnt_id_d   = pick_id;
            hold_cnt_d = '0;
            ptr_d      = (pick_id == IdW'(N - 1)) ? '0 : pick_id + IdW'(1);
          end else begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end else if (hold_cnt_q != {CntW{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= |gnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Self-checking bench for rr_arbiter_hold: three instances (hold limits 4, 2, none)
// compared every cycle against a transaction-level model, plus literal spot checks.
module tb_rr_arbiter_hold;
  import arb_pkg::*;

  typedef struct packed {
    int owner;
    int ptr;
    int held;
    bit tmo;
  } mdl_t;

  localparam mdl_t MdlReset = '{owner: -1, ptr: 0, held: 0, tmo: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  mdl_t mA, mB, mC;

  always #5 clk = ~clk;

  rr_arbiter_hold_if #(.N(8)) ifA ();
  rr_arbiter_hold_if #(.N(8)) ifB ();
  rr_arbiter_hold_if #(.N(5)) ifC ();

  rr_arbiter_hold #(.N(8), .MAX_HOLD(4)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  rr_arbiter_hold #(.N(8), .MAX_HOLD(2)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  rr_arbiter_hold #(.N(5), .MAX_HOLD(0)) dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  // One arbitration edge: keep the owner unless it finishes, abandons or runs out of time.
  function automatic mdl_t mstep(input mdl_t m, input logic [31:0] rq, input logic [31:0] ls,
                                 input int n, input int maxHold);
    mdl_t r;
    bit   forced;
    bit   found;
    r     = m;
    r.tmo = 1'b0;
    if (m.owner >= 0) begin
      forced = (maxHold != 0) && (m.held == maxHold);
      if (!ls[m.owner] && rq[m.owner] && !forced) begin
        r.held = m.held + 1;
        return r;
      end
      r.tmo = forced && !ls[m.owner] && rq[m.owner];
    end
    r.owner = -1;
    r.held  = 0;
    found   = 1'b0;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (m.ptr + k) % n;
      if (rq[idx] && !found) begin
        found   = 1'b1;
        r.owner = idx;
        r.ptr   = (idx + 1) % n;
        r.held  = 1;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] g, input logic [31:0] id,
                             input logic b, input logic t, input logic [31:0] eg,
                             input logic [31:0] eid, input logic eb, input logic et);
    checks++;
    if (g !== eg || id !== eid || b !== eb || t !== et) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got gnt=%h id=%0d busy=%b timeout=%b, want gnt=%h id=%0d busy=%b timeout=%b",
               name, $time, g, id, b, t, eg, eid, eb, et);
    end
  endtask

  task automatic checkModel(input string name, input mdl_t m, input logic [31:0] g,
                            input logic [31:0] id, input logic b, input logic t);
    logic [31:0] eg;
    eg = (m.owner < 0) ? 32'd0 : (32'd1 << m.owner);
    checkOutput(name, g, id, b, t, eg, (m.owner < 0) ? 32'd0 : 32'(m.owner),
                m.owner >= 0, m.tmo);
  endtask

  task automatic litCheck(input string name, input bit useB, input logic [7:0] eg,
                          input int eid, input logic eb, input logic et);
    if (useB)
      checkOutput(name, 32'(ifB.gnt), 32'(ifB.gnt_id), ifB.busy, ifB.timeout,
                  32'(eg), 32'(eid), eb, et);
    else
      checkOutput(name, 32'(ifA.gnt), 32'(ifA.gnt_id), ifA.busy, ifA.timeout,
                  32'(eg), 32'(eid), eb, et);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] l);
    ifA.req  = r;
    ifA.last = l;
    ifB.req  = r;
    ifB.last = l;
    ifC.req  = r[4:0];
    ifC.last = l[4:0];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetPulse();
    applyStimulus(8'h00, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mA <= MdlReset;
      mB <= MdlReset;
      mC <= MdlReset;
    end else begin
      mA <= mstep(mA, 32'(ifA.req), 32'(ifA.last), 8, 4);
      mB <= mstep(mB, 32'(ifB.req), 32'(ifB.last), 8, 2);
      mC <= mstep(mC, 32'(ifC.req), 32'(ifC.last), 5, 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkModel("modelA", mA, 32'(ifA.gnt), 32'(ifA.gnt_id), ifA.busy, ifA.timeout);
      checkModel("modelB", mB, 32'(ifB.gnt), 32'(ifB.gnt_id), ifB.busy, ifB.timeout);
      checkModel("modelC", mC, 32'(ifC.gnt), 32'(ifC.gnt_id), ifC.busy, ifC.timeout);
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] l;
    applyStimulus(8'h00, 8'h00);
    repeat (2) @(negedge clk);
    litCheck("resetState", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    // First grant from ptr 0, zero-bubble handoff on last, then abandon to idle.
    applyStimulus(8'b00100100, 8'h00);
    tick();
    litCheck("firstGrant", 1'b0, 8'b00000100, 2, 1'b1, 1'b0);
    applyStimulus(8'b00100100, 8'b00000100);
    tick();
    litCheck("handoff", 1'b0, 8'b00100000, 5, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00);
    tick();
    litCheck("abandon", 1'b0, 8'h00, 0, 1'b0, 1'b0);

    resetPulse();
    applyStimulus(8'hFF, 8'h00);
    tick();
    litCheck("rotate", 1'b0, 8'h01, 0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'hFF, 8'(1 << (i % 8)));
      tick();
      litCheck("rotate", 1'b0, 8'(1 << ((i + 1) % 8)), (i + 1) % 8, 1'b1, 1'b0);
    end

    resetPulse();
    applyStimulus(8'b00000011, 8'h00);
    for (int c = 0; c < 4; c++) begin
      tick();
      litCheck("holdLimit", 1'b0, 8'h01, 0, 1'b1, 1'b0);
    end
    tick();
    litCheck("forcedRelease", 1'b0, 8'h02, 1, 1'b1, 1'b1);
    tick();
    litCheck("timeoutPulse", 1'b0, 8'h02, 1, 1'b1, 1'b0);

    resetPulse();
    applyStimulus(8'h40, 8'h00);
    tick();
    litCheck("grant6", 1'b0, 8'h40, 6, 1'b1, 1'b0);
    applyStimulus(8'h40, 8'h08);
    tick();
    litCheck("ignoreLast3", 1'b0, 8'h40, 6, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 litCheck("asyncReset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(8'h80, 8'h00);
    tick();
    litCheck("grant7", 1'b0, 8'h80, 7, 1'b1, 1'b0);
    applyStimulus(8'h81, 8'h80);
    tick();
    litCheck("wrapPtr", 1'b0, 8'h01, 0, 1'b1, 1'b0);

    // Sole requester under a limit of 2 is regranted with a timeout every second cycle.
    resetPulse();
    applyStimulus(8'h10, 8'h00);
    tick();
    litCheck("sole4", 1'b1, 8'h10, 4, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      litCheck("sole4Hold", 1'b1, 8'h10, 4, 1'b1, 1'b0);
      tick();
      litCheck("sole4Timeout", 1'b1, 8'h10, 4, 1'b1, 1'b1);
    end

    applyStimulus(8'h01, 8'h00);
    repeat (40) tick();
    applyStimulus(8'h00, 8'h00);
    tick();

    r = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      l = 8'($urandom) & 8'($urandom);
      applyStimulus(r, l);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_hold.md
# rr_arbiter_hold

Round-robin arbiter with grant hold, for sharing one resource among N requesters across multi-cycle transactions. A winner keeps its grant until it signals the last cycle, drops its request, or hits a hold-time limit. The block sits between the requesters and the shared resource's select/enable logic. It provides zero-bubble handoff between successive winners.

## Interface
- `N`, default 8: number of requesters, 2..32, need not be a power of two.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per transaction; 0 disables the limit.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  request per requester; level, held high for the whole transaction.
- `last`  in  N  final-cycle marker; sampled only on the currently granted line.
- `gnt`  out  N  registered one-hot grant, or all-zero.
- `gnt_id`  out  $clog2(N)  registered index of the granted line; 0 when idle.
- `busy`  out  1  registered; equals |gnt.
- `timeout`  out  1  registered one-cycle pulse, set on the cycle after a forced release.

## Operation
- State: `state` ∈ {IDLE, HOLD}, `ptr` (index of the highest-priority requester), `hold_cnt` (0..MAX_HOLD-1).
- Pick: search `req` starting at `ptr`, ascending, wrapping N-1→0. The first set bit wins.
- IDLE, any req: grant the winner, go to HOLD, `hold_cnt`←0, `ptr`←(winner+1) mod N.
- IDLE, no req: outputs stay zero.
- HOLD releases the current grant on any of these:
  - (a) `last[gnt_id]`=1;
  - (b) `req[gnt_id]`=0 (abandon);
  - (c) MAX_HOLD≠0 and `hold_cnt`==MAX_HOLD-1 (forced). `timeout`←1 on the next cycle only if neither (a) nor (b) holds.
- On release, run the pick on the current `req` with the releasing line included.
  - Any winner: regrant at the same edge (no idle cycle), reset `hold_cnt`, update `ptr`.
  - No winner: go to IDLE, clear `gnt`.
- The releasing line has the lowest priority because `ptr` already moved past it. It is regranted only if it is the sole requester.
- HOLD without release: `gnt` and `gnt_id` stay unchanged. `hold_cnt` increments, saturating when MAX_HOLD=0.
- `last` on non-granted lines is ignored. A change in `req` on other lines never preempts the current grant.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
- Asserting `rst` mid-grant clears all outputs immediately (asynchronous).
- After `rst` deasserts, the first grant appears one edge after `req` is sampled high.
- Latency: `req` rising in IDLE → `gnt` set after 1 edge.
- Release: `last` or `req` drop sampled at edge k → new `gnt` (or zero) visible after edge k.
- Forced hold: `gnt` stays high exactly MAX_HOLD cycles, then `timeout`=1 for 1 cycle, coincident with the first cycle of the next grant or of idle.
- `gnt`, `gnt_id`, and `busy` change only together, at the same edge.
- Wrap-around: a winner at N-1 sets `ptr`=0.

## Structure
- Package `arb_pkg`:
  - state encoding `ARB_IDLE` / `ARB_HOLD`;
  - `ptr`/id width helper (clog2, minimum 1);
  - `MAX_HOLD` = 0 sentinel constant.
- Sub-module `rr_pick`, purely combinational: inputs `req[N]`, `ptr`; outputs `pick_onehot[N]`, `pick_id`, `pick_valid`. It is implemented as a double-width mask or rotate plus priority encode.
- Top level: FSM, `ptr`, `hold_cnt`, output registers.

## Test plan
- Reset, then `req`=8'b00100100 with `ptr`=0 → edge 1: `gnt`=8'b00000100, `gnt_id`=2, `ptr`=3. After `last[2]`, next edge: `gnt`=8'b00100000, with no idle cycle.
- All 8 `req` held high, `last` pulsed on each granted line every cycle → grants rotate 0,1,…,7,0 one per cycle, with `busy` continuously 1.
- MAX_HOLD=4, `req`=8'b00000011, no `last` → `gnt[0]` high for exactly 4 cycles, then `gnt`=8'b00000010 with `timeout`=1 for one cycle.
- Granted line 5 drops `req` with no `last`, no other requests → next edge: `gnt`=0, `busy`=0, state IDLE, `timeout`=0.
- `last[3]` while line 6 is granted, and `rst` pulsed mid-HOLD → `last[3]` is ignored; on `rst`, outputs clear immediately. After release, `req`=8'b10000000 → `gnt`=8'b10000000, then `ptr`=0 (wrap).
- Sole requester 4 with MAX_HOLD=2 → regranted back-to-back, with a `timeout` pulse every 2 cycles and `gnt` never dropping.
